// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx serializer: state encoding and sizing helper.
package piso_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } piso_state_e;

  // Number of bits needed to index value distinct positions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Word handshake and serial-side signals of the piso_tx serializer.
interface piso_tx_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             dout;
  logic             dout_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  dout,
    input  dout_valid,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output dout,
    output dout_valid,
    output frame_start,
    output busy
  );

endinterface

// File: rtl/piso_hold_slot.sv
// Single-entry holding register that buffers the next word while the shifter is busy.
module piso_hold_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             unload,
  output logic [WIDTH-1:0] data,
  output logic             full,
  output logic             ready
);

  // Occupancy flag: load and unload are never both asserted by the owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  // Word storage, captured only on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

  // Ready depends on registered state and reset only, never on in_valid.
  assign ready = !rst && !full;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter feeding a downstream sipo stage one bit per clock.
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  piso_tx_if.slave  bus
);

  localparam int unsigned     CW   = clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  piso_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  sh_q, sh_d;
  logic              dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              fs_q, fs_d;

  logic              hold_load;
  logic              hold_unload;
  logic [WIDTH-1:0]  hold_data;
  logic              hold_full;
  logic              in_ready_c;
  logic              accept;

  // Bit that goes on the wire first for a word held in the shifter.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // Drop the bit just sent so the next one sits in the lead position.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  piso_hold_slot #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .load_data (bus.in_data),
    .unload    (hold_unload),
    .data      (hold_data),
    .full      (hold_full),
    .ready     (in_ready_c)
  );

  assign accept = bus.in_valid && in_ready_c;

  // Next-state logic: load from input or hold slot, advance bits, return to idle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    dout_d      = dout_q;
    dv_d        = dv_q;
    fs_d        = 1'b0;
    hold_load   = 1'b0;
    hold_unload = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        dout_d = IDLE_LEVEL;
        dv_d   = 1'b0;
        if (accept) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          sh_d    = bus.in_data;
          dout_d  = lead_bit(bus.in_data);
          dv_d    = 1'b1;
          fs_d    = 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == LAST) begin
          if (hold_full) begin
            cnt_d       = '0;
            sh_d        = hold_data;
            dout_d      = lead_bit(hold_data);
            dv_d        = 1'b1;
            fs_d        = 1'b1;
            hold_unload = 1'b1;
          end else if (accept) begin
            cnt_d  = '0;
            sh_d   = bus.in_data;
            dout_d = lead_bit(bus.in_data);
            dv_d   = 1'b1;
            fs_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            dout_d  = IDLE_LEVEL;
            dv_d    = 1'b0;
          end
        end else begin
          cnt_d     = cnt_q + CW'(1);
          sh_d      = shift_once(sh_q);
          dout_d    = lead_bit(shift_once(sh_q));
          dv_d      = 1'b1;
          hold_load = accept;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, shifter and serial output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= IDLE_LEVEL;
      dv_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dv_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = (state_q == S_SHIFT) || hold_full;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: MSB-first and LSB-first instances on a shared clock.
module tb_piso_tx;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(W)) bus0 ();
  piso_tx_if #(.WIDTH(W)) bus1 ();

  piso_tx #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  piso_tx #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int total = 0;
  int bad   = 0;

  // Expected serial stream entries: {bit, frame_start}.
  logic [1:0] q0[$];
  logic [1:0] q1[$];

  function automatic void push0(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) q0.push_back({w[W-1-i], (i == 0)});
  endfunction

  function automatic void push1(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) q1.push_back({w[i], (i == 0)});
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus0.in_valid = 1'b0;
    bus0.in_data  = '0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;
    @(negedge clk);
    total++;
    if ({bus0.dout, bus0.dout_valid, bus0.frame_start, bus0.busy, bus0.in_ready} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_msb: {dout,dv,fs,busy,rdy} got %b expected 00000",
               {bus0.dout, bus0.dout_valid, bus0.frame_start, bus0.busy, bus0.in_ready});
    end
    total++;
    if ({bus1.dout, bus1.dout_valid, bus1.frame_start, bus1.busy, bus1.in_ready} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_lsb: {dout,dv,fs,busy,rdy} got %b expected 00000",
               {bus1.dout, bus1.dout_valid, bus1.frame_start, bus1.busy, bus1.in_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({bus0.in_ready, bus1.in_ready} !== 2'b11) begin
      bad++;
      $display("FAIL reset_release_ready: got %b expected 11", {bus0.in_ready, bus1.in_ready});
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if ({bus0.dout, bus0.dout_valid, bus0.busy, bus0.in_ready} !== 4'b0001) begin
        bad++;
        $display("FAIL idle_c%0d: {dout,dv,busy,rdy} got %b expected 0001", c,
                 {bus0.dout, bus0.dout_valid, bus0.busy, bus0.in_ready});
      end
    end
  endtask

  task automatic test_single();
    logic [1:0] e;
    int nvalid = 0;
    int nfs    = 0;
    @(negedge clk);
    bus0.in_data  = 8'hA5;
    bus0.in_valid = 1'b1;
    total++;
    if (bus0.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_ready: got %b expected 1", bus0.in_ready);
    end
    if (bus0.in_ready === 1'b1) push0(8'hA5);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus0.dout_valid === 1'b1) begin
        nvalid++;
        if (bus0.frame_start === 1'b1) nfs++;
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL single_extra_bit c%0d: dout_valid got 1 expected 0", c);
        end else begin
          e = q0.pop_front();
          if ({bus0.dout, bus0.frame_start} !== e) begin
            bad++;
            $display("FAIL single_bit c%0d: {dout,fs} got %b expected %b", c,
                     {bus0.dout, bus0.frame_start}, e);
          end
        end
      end else begin
        total++;
        if ({bus0.dout, bus0.frame_start} !== 2'b00) begin
          bad++;
          $display("FAIL single_idle_level c%0d: {dout,fs} got %b expected 00", c,
                   {bus0.dout, bus0.frame_start});
        end
      end
      bus0.in_valid = 1'b0;
      bus0.in_data  = W'($urandom);
    end
    total++;
    if (nvalid != 8 || nfs != 1) begin
      bad++;
      $display("FAIL single_counts: valid=%0d fs=%0d expected valid=8 fs=1", nvalid, nfs);
    end
    total++;
    if ({bus0.busy, bus0.dout, q0.size() == 0} !== 3'b001) begin
      bad++;
      $display("FAIL single_end: busy=%b dout=%b pending=%0d expected 0 0 0",
               bus0.busy, bus0.dout, q0.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words[3];
    logic [1:0]   e;
    logic         exp_dv, exp_fs, exp_rdy;
    int idx = 0;
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'hFF;
    @(negedge clk);
    bus0.in_valid = 1'b1;
    bus0.in_data  = words[0];
    if (bus0.in_ready === 1'b1) begin
      push0(words[0]);
      idx = 1;
    end
    for (int j = 0; j < 26; j++) begin
      @(negedge clk);
      exp_dv  = (j < 24);
      exp_fs  = (j == 0) || (j == 8) || (j == 16);
      exp_rdy = (j == 0) || (j == 8) || (j >= 16);
      total++;
      if ({bus0.dout_valid, bus0.frame_start, bus0.in_ready} !== {exp_dv, exp_fs, exp_rdy}) begin
        bad++;
        $display("FAIL b2b_ctrl j%0d: {dv,fs,rdy} got %b expected %b", j,
                 {bus0.dout_valid, bus0.frame_start, bus0.in_ready}, {exp_dv, exp_fs, exp_rdy});
      end
      if (bus0.dout_valid === 1'b1) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra_bit j%0d: dout_valid got 1 expected 0", j);
        end else begin
          e = q0.pop_front();
          if ({bus0.dout, bus0.frame_start} !== e) begin
            bad++;
            $display("FAIL b2b_bit j%0d: {dout,fs} got %b expected %b", j,
                     {bus0.dout, bus0.frame_start}, e);
          end
        end
      end
      if (idx < 3) begin
        bus0.in_valid = 1'b1;
        bus0.in_data  = words[idx];
        if (bus0.in_ready === 1'b1) begin
          push0(words[idx]);
          idx++;
        end
      end else begin
        bus0.in_valid = 1'b0;
      end
    end
    total++;
    if (q0.size() != 0 || idx != 3) begin
      bad++;
      $display("FAIL b2b_drain: pending=%0d sent=%0d expected 0 and 3", q0.size(), idx);
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] words[2];
    logic [1:0]   e;
    logic         exp_dv, exp_fs;
    int idx = 0;
    words[0] = 8'h01;
    words[1] = 8'h80;
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.in_data  = words[0];
    if (bus1.in_ready === 1'b1) begin
      push1(words[0]);
      idx = 1;
    end
    for (int j = 0; j < 19; j++) begin
      @(negedge clk);
      exp_dv = (j < 16);
      exp_fs = (j == 0) || (j == 8);
      total++;
      if ({bus1.dout_valid, bus1.frame_start} !== {exp_dv, exp_fs}) begin
        bad++;
        $display("FAIL lsb_ctrl j%0d: {dv,fs} got %b expected %b", j,
                 {bus1.dout_valid, bus1.frame_start}, {exp_dv, exp_fs});
      end
      if (bus1.dout_valid === 1'b1) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL lsb_extra_bit j%0d: dout_valid got 1 expected 0", j);
        end else begin
          e = q1.pop_front();
          if ({bus1.dout, bus1.frame_start} !== e) begin
            bad++;
            $display("FAIL lsb_bit j%0d: {dout,fs} got %b expected %b", j,
                     {bus1.dout, bus1.frame_start}, e);
          end
        end
      end
      if (idx < 2) begin
        bus1.in_valid = 1'b1;
        bus1.in_data  = words[idx];
        if (bus1.in_ready === 1'b1) begin
          push1(words[idx]);
          idx++;
        end
      end else begin
        bus1.in_valid = 1'b0;
      end
    end
    total++;
    if (q1.size() != 0 || bus1.busy !== 1'b0 || bus1.dout !== 1'b0) begin
      bad++;
      $display("FAIL lsb_end: pending=%0d busy=%b dout=%b expected 0 0 0",
               q1.size(), bus1.busy, bus1.dout);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [1:0] e;
    int nvalid = 0;
    @(negedge clk);
    bus0.in_valid = 1'b1;
    bus0.in_data  = 8'hF0;
    if (bus0.in_ready === 1'b1) push0(8'hF0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      total++;
      if (q0.size() == 0 || bus0.dout_valid !== 1'b1) begin
        bad++;
        $display("FAIL rstmid_pre j%0d: dv got %b expected 1 with word pending", j, bus0.dout_valid);
      end else begin
        e = q0.pop_front();
        if ({bus0.dout, bus0.frame_start} !== e) begin
          bad++;
          $display("FAIL rstmid_pre_bit j%0d: {dout,fs} got %b expected %b", j,
                   {bus0.dout, bus0.frame_start}, e);
        end
      end
      bus0.in_valid = 1'b1;
      bus0.in_data  = 8'h0F;
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus0.dout, bus0.dout_valid, bus0.frame_start, bus0.busy, bus0.in_ready} !== 5'b00000) begin
      bad++;
      $display("FAIL rstmid_async: {dout,dv,fs,busy,rdy} got %b expected 00000",
               {bus0.dout, bus0.dout_valid, bus0.frame_start, bus0.busy, bus0.in_ready});
    end
    q0.delete();
    bus0.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({bus0.in_ready, bus0.busy, bus0.dout_valid} !== 3'b100) begin
      bad++;
      $display("FAIL rstmid_release: {rdy,busy,dv} got %b expected 100",
               {bus0.in_ready, bus0.busy, bus0.dout_valid});
    end
    bus0.in_valid = 1'b1;
    bus0.in_data  = 8'h81;
    if (bus0.in_ready === 1'b1) push0(8'h81);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      bus0.in_valid = 1'b0;
      if (bus0.dout_valid === 1'b1) begin
        nvalid++;
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL rstmid_stale_bit c%0d: dout_valid got 1 expected 0", c);
        end else begin
          e = q0.pop_front();
          if ({bus0.dout, bus0.frame_start} !== e) begin
            bad++;
            $display("FAIL rstmid_bit c%0d: {dout,fs} got %b expected %b", c,
                     {bus0.dout, bus0.frame_start}, e);
          end
        end
      end
    end
    total++;
    if (nvalid != 8 || q0.size() != 0) begin
      bad++;
      $display("FAIL rstmid_count: valid=%0d pending=%0d expected 8 and 0", nvalid, q0.size());
    end
  endtask

  task automatic test_loopback();
    logic [W-1:0] wq[$];
    logic [W-1:0] acc;
    logic [W-1:0] cur;
    logic [W-1:0] exp_w;
    int nb      = 0;
    int got     = 0;
    int sent    = 0;
    int gaps    = 0;
    bit started = 1'b0;
    acc = '0;
    cur = W'($urandom);
    @(negedge clk);
    bus0.in_valid = 1'b1;
    bus0.in_data  = cur;
    if (bus0.in_ready === 1'b1) begin
      wq.push_back(cur);
      sent++;
      cur = W'($urandom);
    end
    for (int j = 0; j < 150 && got < 10; j++) begin
      @(negedge clk);
      if (bus0.dout_valid === 1'b1) begin
        started = 1'b1;
        if (bus0.frame_start === 1'b1) begin
          acc = {{(W-1){1'b0}}, bus0.dout};
          nb  = 1;
        end else begin
          acc = {acc[W-2:0], bus0.dout};
          nb++;
        end
        if (nb == W) begin
          total++;
          if (wq.size() == 0) begin
            bad++;
            $display("FAIL loop_extra_word: got %h with nothing outstanding", acc);
          end else begin
            exp_w = wq.pop_front();
            if (acc !== exp_w) begin
              bad++;
              $display("FAIL loop_word%0d: got %h expected %h", got, acc, exp_w);
            end
          end
          got++;
          nb = 0;
        end
      end else if (started) begin
        gaps++;
      end
      if (sent < 10) begin
        bus0.in_valid = 1'b1;
        bus0.in_data  = cur;
        if (bus0.in_ready === 1'b1) begin
          wq.push_back(cur);
          sent++;
          cur = W'($urandom);
        end
      end else begin
        bus0.in_valid = 1'b0;
      end
    end
    bus0.in_valid = 1'b0;
    total++;
    if (got != 10 || wq.size() != 0 || gaps != 0) begin
      bad++;
      $display("FAIL loop_summary: words=%0d pending=%0d gaps=%0d expected 10 0 0",
               got, wq.size(), gaps);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
